// File: rtl/maze_tx_checker.sv
// -----------------------------------------------------------------------------
// maze_tx_checker
//
// Serial-interface partner for the maze solver. A 15x15 maze is written into
// a local store one row at a time. On start it is streamed bit-serially to
// the solver. The solver's answer is then consumed and judged: either an
// "unsolvable" report, or a path of coordinates that must run from the
// bottom-right interior corner to the top-left one through open cells in
// 4-connected steps.
//
// Ports
//   clk                clock
//   rst_n              synchronous active-low reset
//   row_we_i           write row_data_i into row row_addr_i (IDLE only)
//   row_addr_i [3:0]   row index 0..N-1, larger values are dropped
//   row_data_i [N-1:0] bit c = column c, 1 = wall, 0 = open
//   start_i            begin a run (IDLE only)
//   maze_o             serial maze bit to the solver
//   in_valid_o         qualifies maze_o
//   out_valid_i        solver response beat
//   maze_not_valid_i   solver reports no path (qualified by out_valid_i)
//   out_x_i [3:0]      path column
//   out_y_i [3:0]      path row
//   busy_o             high in every state except IDLE
//   done_o             one-cycle pulse when a run finishes
//   result_o [1:0]     0 path ok, 1 unsolvable, 2 path error, 3 timeout
//   path_len_o [7:0]   path beats received, saturating at 255
// -----------------------------------------------------------------------------
module maze_tx_checker #(
    parameter int N       = 15,    // maze side, at most 15 for 4-bit coordinates
    parameter int TIMEOUT = 4096   // WAIT cycles allowed before giving up
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         row_we_i,
    input  logic [3:0]   row_addr_i,
    input  logic [N-1:0] row_data_i,
    input  logic         start_i,
    output logic         maze_o,
    output logic         in_valid_o,
    input  logic         out_valid_i,
    input  logic         maze_not_valid_i,
    input  logic [3:0]   out_x_i,
    input  logic [3:0]   out_y_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [1:0]   result_o,
    output logic [7:0]   path_len_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    LAST     = 4'(N - 1);  // last row/column index
    localparam logic [3:0]    HI       = 4'(N - 2);  // highest interior index
    localparam logic [3:0]    ROWS     = 4'(N);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        RES_OK       = 2'd0,
        RES_UNSOLV   = 2'd1,
        RES_PATH_ERR = 2'd2,
        RES_TIMEOUT  = 2'd3
    } result_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q,    state_d;
    logic [N-1:0]    store_q [N];
    logic [N-1:0]    store_d [N];
    logic [3:0]      row_q,      row_d;       // coordinate of the beat on maze_o
    logic [3:0]      col_q,      col_d;
    logic            maze_q,     maze_d;
    logic            in_valid_q, in_valid_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    result_e         result_q,   result_d;
    logic [7:0]      path_len_q, path_len_d;
    logic            err_q,      err_d;       // sticky path violation
    logic [TW-1:0]   tmo_q,      tmo_d;
    logic [3:0]      prev_x_q,   prev_x_d;    // previous accepted path beat
    logic [3:0]      prev_y_q,   prev_y_d;

    // -------------------------------------------------------------------------
    // Path beat judgement (pure function of the current beat and history)
    // -------------------------------------------------------------------------
    logic         in_range;
    logic [N-1:0] sel_row;
    logic         cell_wall;
    logic [3:0]   dx;
    logic [3:0]   dy;
    logic         adjacent;
    logic         first_ok;
    logic         step_ok;
    logic         beat_bad;
    logic [7:0]   path_len_inc;

    always_comb begin
        in_range = (out_x_i >= 4'd1) && (out_x_i <= HI) &&
                   (out_y_i >= 4'd1) && (out_y_i <= HI);

        // The store lookup is only meaningful for in-range rows; anything
        // outside the interior is already a violation, so treat it as wall.
        sel_row   = (out_y_i < ROWS) ? store_q[out_y_i] : '1;
        cell_wall = in_range ? sel_row[out_x_i] : 1'b1;

        dx = (out_x_i > prev_x_q) ? (out_x_i - prev_x_q) : (prev_x_q - out_x_i);
        dy = (out_y_i > prev_y_q) ? (out_y_i - prev_y_q) : (prev_y_q - out_y_i);
        adjacent = ({1'b0, dx} + {1'b0, dy}) == 5'd1;

        first_ok = (out_x_i == HI) && (out_y_i == HI);

        // In WAIT the beat is the first of the path: it has no predecessor and
        // must sit on the entry corner instead of being adjacent to anything.
        step_ok  = (state_q == S_WAIT) ? first_ok : adjacent;

        beat_bad = !in_range || cell_wall || !step_ok ||
                   ((state_q == S_CHECK) && maze_not_valid_i);

        path_len_inc = (path_len_q == 8'hFF) ? 8'hFF : (path_len_q + 8'd1);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in this block gets a default first, so
        // no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d    = state_q;
        store_d    = store_q;
        row_d      = row_q;
        col_d      = col_q;
        maze_d     = maze_q;
        in_valid_d = in_valid_q;
        done_d     = 1'b0;
        result_d   = result_q;
        path_len_d = path_len_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;

        // Row writes are only honoured while idle; they are resolved before
        // the start handling so a write in the start cycle is part of the
        // streamed maze.
        if ((state_q == S_IDLE) && row_we_i && (row_addr_i < ROWS)) begin
            store_d[row_addr_i] = row_data_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_SEND;
                    row_d      = 4'd0;
                    col_d      = 4'd0;
                    maze_d     = store_d[0][0];
                    in_valid_d = 1'b1;
                    result_d   = RES_OK;
                    path_len_d = 8'd0;
                    err_d      = 1'b0;
                    tmo_d      = '0;
                end
            end

            S_SEND: begin
                if ((row_q == LAST) && (col_q == LAST)) begin
                    state_d    = S_WAIT;
                    maze_d     = 1'b0;
                    in_valid_d = 1'b0;
                    tmo_d      = '0;
                end else if (col_q == LAST) begin
                    row_d  = row_q + 4'd1;
                    col_d  = 4'd0;
                    maze_d = store_q[row_q + 4'd1][0];
                end else begin
                    col_d  = col_q + 4'd1;
                    maze_d = store_q[row_q][col_q + 4'd1];
                end
            end

            S_WAIT: begin
                if (out_valid_i) begin
                    if (maze_not_valid_i) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = RES_UNSOLV;
                    end else begin
                        state_d    = S_CHECK;
                        err_d      = beat_bad;
                        path_len_d = path_len_inc;
                        prev_x_d   = out_x_i;
                        prev_y_d   = out_y_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = RES_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_CHECK: begin
                if (out_valid_i) begin
                    err_d      = err_q | beat_bad;
                    path_len_d = path_len_inc;
                    prev_x_d   = out_x_i;
                    prev_y_d   = out_y_i;
                end else begin
                    // Stream ended: the path must have arrived at the exit.
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = (err_q || (prev_x_q != 4'd1) || (prev_y_q != 4'd1))
                             ? RES_PATH_ERR : RES_OK;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge, independent of
        // statement order.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            // NOTE: the maze store is reset on purpose: a run started right
            // after reset must stream a defined all-open maze, so it is built
            // from resettable flops rather than a RAM macro.
            for (int r = 0; r < N; r++) begin
                store_q[r] <= '0;
            end
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            maze_q     <= 1'b0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= RES_OK;
            path_len_q <= 8'd0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
            prev_x_q   <= 4'd0;
            prev_y_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            row_q      <= row_d;
            col_q      <= col_d;
            maze_q     <= maze_d;
            in_valid_q <= in_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            path_len_q <= path_len_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
        end
    end

    assign maze_o     = maze_q;
    assign in_valid_o = in_valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign path_len_o = path_len_q;

endmodule

// File: tb/tb_maze_tx_checker.sv
// -----------------------------------------------------------------------------
// tb_maze_tx_checker
//
// Directed bench for maze_tx_checker. A local copy of the maze store follows
// every accepted row write; the serial stream is compared against it beat by
// beat. When a solver response is driven, the expected result/path length is
// derived from the path rules applied to the local maze and pushed into a
// scoreboard queue; it is popped when done_o pulses.
// -----------------------------------------------------------------------------
module tb_maze_tx_checker;

    localparam int N       = 15;
    localparam int TIMEOUT = 4096;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         row_we_i;
    logic [3:0]   row_addr_i;
    logic [N-1:0] row_data_i;
    logic         start_i;
    logic         maze_o;
    logic         in_valid_o;
    logic         out_valid_i;
    logic         maze_not_valid_i;
    logic [3:0]   out_x_i;
    logic [3:0]   out_y_i;
    logic         busy_o;
    logic         done_o;
    logic [1:0]   result_o;
    logic [7:0]   path_len_o;

    always #5 clk = ~clk;

    maze_tx_checker #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .row_we_i         (row_we_i),
        .row_addr_i       (row_addr_i),
        .row_data_i       (row_data_i),
        .start_i          (start_i),
        .maze_o           (maze_o),
        .in_valid_o       (in_valid_o),
        .out_valid_i      (out_valid_i),
        .maze_not_valid_i (maze_not_valid_i),
        .out_x_i          (out_x_i),
        .out_y_i          (out_y_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .result_o         (result_o),
        .path_len_o       (path_len_o)
    );

    typedef struct {
        logic [1:0] result;
        logic [7:0] path_len;
    } exp_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
    } beat_t;

    exp_t         sb [$];
    beat_t        path [$];
    logic [N-1:0] model [N];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [3:0] a, input logic [N-1:0] d);
        row_we_i   = 1'b1;
        row_addr_i = a;
        row_data_i = d;
        tick();
        row_we_i = 1'b0;
        if (a < N) model[a] = d;
    endtask

    task automatic add_beat(input int x, input int y);
        beat_t b;
        b.x = 4'(x);
        b.y = 4'(y);
        path.push_back(b);
    endtask

    // Path rules applied to the bench's own maze copy.
    function automatic exp_t ref_expect();
        exp_t e;
        bit   err;
        int   x, y, px, py, dx, dy;
        err = 1'b0;
        px  = 0;
        py  = 0;
        for (int i = 0; i < path.size(); i++) begin
            x = int'(path[i].x);
            y = int'(path[i].y);
            if (x < 1 || x > N - 2 || y < 1 || y > N - 2) err = 1'b1;
            else if (model[y][x]) err = 1'b1;
            if (i == 0) begin
                if (x != N - 2 || y != N - 2) err = 1'b1;
            end else begin
                dx = (x > px) ? x - px : px - x;
                dy = (y > py) ? y - py : py - y;
                if (dx + dy != 1) err = 1'b1;
            end
            px = x;
            py = y;
        end
        if (path.size() == 0 || px != 1 || py != 1) err = 1'b1;
        e.result   = err ? 2'd2 : 2'd0;
        e.path_len = (path.size() > 255) ? 8'hFF : 8'(path.size());
        return e;
    endfunction

    // Start a run and compare all N*N serial beats against the model.
    // Optional row write in the start cycle; optional row_we+start poke at
    // beat we_at, which must have no effect.
    task automatic stream(input string tag, input bit spot, input int we_at,
                          input bit st_we, input logic [3:0] st_addr,
                          input logic [N-1:0] st_data);
        int   bad, first_bad;
        logic b0, b16;
        bad       = 0;
        first_bad = -1;
        b0        = 1'b0;
        b16       = 1'b0;
        start_i   = 1'b1;
        if (st_we) begin
            row_we_i   = 1'b1;
            row_addr_i = st_addr;
            row_data_i = st_data;
            if (st_addr < N) model[st_addr] = st_data;
        end
        tick();
        start_i  = 1'b0;
        row_we_i = 1'b0;
        check({tag, " busy at first beat"}, busy_o, 1);
        for (int k = 0; k < N * N; k++) begin
            if (in_valid_o !== 1'b1 || maze_o !== model[k / N][k % N]) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            if (k == 0)  b0  = maze_o;
            if (k == 16) b16 = maze_o;
            row_we_i = (k == we_at);
            start_i  = (k == we_at);
            if (k == we_at) begin
                row_addr_i = 4'd5;
                row_data_i = '1;
            end
            tick();
        end
        row_we_i = 1'b0;
        start_i  = 1'b0;
        check({tag, " serial beat errors"}, bad, 0);
        check({tag, " first bad beat"}, first_bad, -1);
        if (spot) begin
            check({tag, " beat0 bit(0,0)"}, b0, 1);
            check({tag, " beat16 bit(1,1)"}, b16, 0);
        end
        check({tag, " in_valid low after N*N"}, in_valid_o, 0);
        check({tag, " busy in WAIT"}, busy_o, 1);
    endtask

    // Wait (bounded) for done_o, check its latency and pop the scoreboard.
    task automatic wait_done(input string tag, input int exp_lat, input int poke_at);
        int   n;
        bit   seen;
        int   iv_bad;
        exp_t e;
        n      = 0;
        seen   = 1'b0;
        iv_bad = 0;
        while (n < TIMEOUT + 32) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            start_i = (n == poke_at);
            tick();
            n++;
            start_i          = 1'b0;
            out_valid_i      = 1'b0;
            maze_not_valid_i = 1'b0;
            if (in_valid_o !== 1'b0) iv_bad++;
        end
        check({tag, " done seen"}, seen, 1);
        check({tag, " done latency"}, n, exp_lat);
        check({tag, " no restream while waiting"}, iv_bad, 0);
        check({tag, " scoreboard not empty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " result"}, result_o, e.result);
            check({tag, " path_len"}, path_len_o, e.path_len);
            tick();
            check({tag, " done is one pulse"}, done_o, 0);
            check({tag, " idle after done"}, busy_o, 0);
            check({tag, " result holds"}, result_o, e.result);
            check({tag, " path_len holds"}, path_len_o, e.path_len);
        end
    endtask

    task automatic send_path(input string tag);
        int done_bad;
        done_bad = 0;
        sb.push_back(ref_expect());
        for (int i = 0; i < path.size(); i++) begin
            out_valid_i      = 1'b1;
            maze_not_valid_i = 1'b0;
            out_x_i          = path[i].x;
            out_y_i          = path[i].y;
            tick();
            if (done_o !== 1'b0) done_bad++;
        end
        out_valid_i = 1'b0;
        check({tag, " done low during stream"}, done_bad, 0);
        wait_done(tag, 1, -1);
    endtask

    task automatic send_unsolvable(input string tag);
        exp_t e;
        e.result   = 2'd1;
        e.path_len = 8'd0;
        sb.push_back(e);
        out_valid_i      = 1'b1;
        maze_not_valid_i = 1'b1;
        out_x_i          = 4'd0;
        out_y_i          = 4'd0;
        wait_done(tag, 1, -1);
    endtask

    initial begin
        exp_t e;

        rst_n            = 1'b0;
        row_we_i         = 1'b0;
        row_addr_i       = 4'd0;
        row_data_i       = '0;
        start_i          = 1'b0;
        out_valid_i      = 1'b0;
        maze_not_valid_i = 1'b0;
        out_x_i          = 4'd0;
        out_y_i          = 4'd0;
        for (int r = 0; r < N; r++) model[r] = '0;

        // Reset state
        tick();
        tick();
        check("rst maze", maze_o, 0);
        check("rst in_valid", in_valid_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst result", result_o, 0);
        check("rst path_len", path_len_o, 0);
        rst_n = 1'b1;
        tick();

        // Open interior, border walls
        for (int r = 0; r < N; r++) begin
            if (r == 0 || r == N - 1) write_row(4'(r), '1);
            else                      write_row(4'(r), 15'h4001);
        end

        // Legal 25-beat path
        stream("open", 1'b1, -1, 1'b0, 4'd0, '0);
        path.delete();
        for (int x = 13; x >= 1; x--) add_beat(x, 13);
        for (int y = 12; y >= 1; y--) add_beat(1, y);
        send_path("good path");

        // Diagonal step mid-path; row_we/start during SEND are ignored
        stream("send poke", 1'b0, 10, 1'b0, 4'd0, '0);
        path.delete();
        for (int x = 13; x >= 5; x--) add_beat(x, 13);
        for (int y = 12; y >= 5; y--) add_beat(5, y);
        add_beat(6, 6);
        for (int y = 5; y >= 1; y--) add_beat(6, y);
        for (int x = 5; x >= 1; x--) add_beat(x, 1);
        send_path("diagonal");

        // Wall on the entry cell; solver answers unsolvable
        write_row(4'd13, 15'h4001 | 15'h2000);
        stream("entry wall", 1'b0, -1, 1'b0, 4'd0, '0);
        send_unsolvable("unsolvable");

        // Out-of-range row write with start; then no answer -> timeout,
        // with a start poke during WAIT
        stream("bad addr", 1'b0, -1, 1'b1, 4'd15, '1);
        e.result   = 2'd3;
        e.path_len = 8'd0;
        sb.push_back(e);
        wait_done("timeout", TIMEOUT, 100);

        // Reset during SEND beat 100
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        check("mid-send in_valid before rst", in_valid_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < N; r++) model[r] = '0;
        check("abort in_valid", in_valid_o, 0);
        check("abort busy", busy_o, 0);
        check("abort done", done_o, 0);
        check("abort maze", maze_o, 0);
        check("abort result", result_o, 0);
        check("abort path_len", path_len_o, 0);

        // Cleared store streams all zeros
        stream("cleared", 1'b0, -1, 1'b0, 4'd0, '0);
        send_unsolvable("cleared unsolvable");

        // Row write in the start cycle lands in the stream; path ends short
        stream("we with start", 1'b0, -1, 1'b1, 4'd0, 15'h5555);
        path.delete();
        add_beat(13, 13);
        add_beat(12, 13);
        add_beat(12, 12);
        send_path("short path");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_tx_checker.md
Name: maze_tx_checker

Overview:
- Opposite end of the serial maze interface used by the team's maze solver.
- Holds a 15x15 maze written row by row, then streams it bit-serially on maze/in_valid.
- Consumes the solver's out_valid/out_x/out_y (or maze_not_valid) response and checks that the returned path is legal.
- Used as an on-chip stimulus/self-check engine in front of the solver.

Parameters:
N, 15, maze side length (outer ring is wall; interior coordinates 1..N-2)
TIMEOUT, 4096, max cycles in WAIT without out_valid before declaring timeout

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
row_we  input  1  write row_data into maze row row_addr (accepted in IDLE only)
row_addr  input  4  row index 0..N-1; values >= N ignored
row_data  input  N  bit c = column c, 1 = wall, 0 = open
start  input  1  begin transmission (accepted in IDLE only)
maze  output  1  serial maze bit to solver
in_valid  output  1  qualifies maze
out_valid  input  1  solver response beat
maze_not_valid  input  1  solver reports no path (qualified by out_valid)
out_x  input  4  path column
out_y  input  4  path row
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a run finishes
result  output  2  0 path ok, 1 solver reported unsolvable, 2 path error, 3 timeout
path_len  output  8  number of path beats received, saturating at 255

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: maze=0, in_valid=0, busy=0, done=0, result=0, path_len=0, maze store cleared to all 0, state=IDLE.
- Reset asserted mid-operation aborts the run immediately. No done pulse is generated.

States: IDLE -> SEND -> WAIT -> CHECK -> DONE -> IDLE.

IDLE:
- row_we writes the store on the clock edge.
- start sampled high -> SEND. Clear path_len, result, error flag and timeout counter.
- row_we and start in the same cycle: the write lands, and the transmitted maze includes it.
- row_we outside IDLE is ignored. start outside IDLE is ignored.

SEND:
- in_valid is high for exactly N*N consecutive cycles, starting the cycle after start is sampled.
- Beat k carries bit (row k/N, column k%N): row 0 first, column 0 first within each row.
- After beat N*N-1, in_valid=0 and the state moves to WAIT.
- out_valid during SEND is ignored.

WAIT:
- The timeout counter increments each cycle.
- Reaching TIMEOUT without out_valid -> result=3, then DONE.
- out_valid=1 with maze_not_valid=1 -> result=1, then DONE.
- out_valid=1 with maze_not_valid=0 -> process the beat as the first path beat, then CHECK.

Path beat rules:
- First beat must be (out_x,out_y)=(N-2,N-2).
- Each later beat must be 4-adjacent to the previous beat: |dx|+|dy| = 1.
- Every beat must lie within 1..N-2 and be an open cell in the store.
- Any violation sets a sticky error flag.
- Each beat increments path_len, saturating at 255.

CHECK:
- Each out_valid=1 beat is processed by the path beat rules.
- maze_not_valid=1 in CHECK is a violation.
- out_valid=0 ends the stream. The last beat must be (1,1), otherwise it is an error.
- result = 2 if error, else 0. Then DONE.
- Because the error flag is sticky, the stream is always consumed to its end. The block never returns to IDLE mid-stream.

DONE:
- done=1 for one cycle, then IDLE.
- result and path_len hold until the next accepted start.

Timing:
- Latency from start to first in_valid: 1 cycle.
- done rises 1 cycle after out_valid falls (CHECK), or 1 cycle after the maze_not_valid beat or timeout (WAIT).

Test Plan:
- Open interior, all border walls; start -> in_valid high 225 cycles; first beat is bit(0,0)=1, beat 16 is 0. Solver path of 25 beats from (13,13) to (1,1) -> done, result=0, path_len=25.
- Same maze; bench response with a diagonal step (5,5)->(6,6) mid-path -> result=2. done only after out_valid falls.
- Wall at (row 13, col 13); response is one beat with maze_not_valid=1 -> result=1, path_len=0, done one cycle later.
- No response after SEND -> done exactly TIMEOUT cycles after in_valid falls, result=3.
- row_we with row_addr=15 plus start in the same cycle -> store unchanged. row_we during SEND is ignored, checked via the serial bits. start during WAIT is ignored.
- rst_n low during SEND beat 100 -> next cycle in_valid=0, busy=0, store all zero. A fresh start afterwards streams 225 zero-interior bits.
